sd_rx_pack_fifo: RTL

SD_RX_PACK_FIFO -- requirements
Module: sd_rx_pack_fifo

---
 rtl/sd_pkg.sv | 20 ++
 rtl/sd_rx_packer.sv | 89 ++++++++
 rtl/sd_rx_pack_fifo.sv | 85 ++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - SD bus-width encodings and unit-width lookup
package sd_pkg;

    typedef enum logic [1:0] {
        BW_1   = 2'b00,
        BW_4   = 2'b01,
        BW_8   = 2'b10,
        BW_4_X = 2'b11
    } bus_width_e;

    // The reserved encoding behaves as 4-bit mode.
    function automatic logic [3:0] unit_width(input logic [1:0] bw);
        case (bw)
            BW_1:    return 4'd1;
            BW_8:    return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/sd_rx_packer.sv
// rtl/sd_rx_packer.sv - MSB-first packer of 1/4/8-bit SD units into DW-bit words
module sd_rx_packer
    import sd_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    bus_width,
    input  logic [7:0]    d,
    input  logic          wr,
    input  logic          flush,
    output logic          push,
    output logic [DW-1:0] push_data
);

    localparam int CW = $clog2(DW) + 1;
    localparam int UW = CW + 3;

    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] sr_q, sr_d;
    logic [1:0]    bw_q, bw_d;

    logic [CW-1:0] count_eff, cnt_n, per_word;
    logic [DW-1:0] base, shifted, unit_w, acc;
    logic [3:0]    w;
    logic [UW-1:0] used, pad;

    always_comb begin
        bw_d      = bus_width;
        // A mode change between cycles abandons whatever was partially packed.
        count_eff = (bus_width != bw_q) ? '0 : count_q;
        base      = (count_eff == '0) ? '0 : sr_q;
        w         = unit_width(bus_width);
        shifted   = base;
        unit_w    = '0;
        per_word  = CW'(DW / 4);
        case (w)
            4'd1: begin
                shifted  = base << 1;
                unit_w   = DW'(d[0]);
                per_word = CW'(DW);
            end
            4'd8: begin
                shifted  = base << 8;
                unit_w   = DW'(d);
                per_word = CW'(DW / 8);
            end
            default: begin
                shifted  = base << 4;
                unit_w   = DW'(d[3:0]);
                per_word = CW'(DW / 4);
            end
        endcase
        acc   = wr ? (shifted | unit_w) : base;
        cnt_n = wr ? (count_eff + CW'(1)) : count_eff;
        used  = UW'(cnt_n) * UW'(w);
        pad   = UW'(DW) - used;

        push      = 1'b0;
        push_data = acc;
        count_d   = cnt_n;
        sr_d      = acc;
        if (wr && (cnt_n == per_word)) begin
            push    = 1'b1;
            count_d = '0;
            sr_d    = '0;
        end else if (flush && (cnt_n != '0)) begin
            // Units accumulate right-aligned; left-justify so padding lands low.
            push      = 1'b1;
            push_data = acc << pad;
            count_d   = '0;
            sr_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sr_q    <= '0;
            bw_q    <= BW_1;
        end else begin
            count_q <= count_d;
            sr_q    <= sr_d;
            bw_q    <= bw_d;
        end
    end

endmodule

// File: rtl/sd_rx_pack_fifo.sv
// rtl/sd_rx_pack_fifo.sv - SD receive packer feeding a show-ahead word FIFO
module sd_rx_pack_fifo #(
    parameter int DW     = 32,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 bus_width,
    input  logic [7:0]                 d,
    input  logic                       wr,
    input  logic                       flush,
    output logic [DW-1:0]              q,
    input  logic                       rd,
    output logic                       full,
    output logic                       empty,
    output logic                       afull,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic          push;
    logic [DW-1:0] push_data;

    logic [LW-1:0] wptr_q, wptr_d;
    logic [LW-1:0] rptr_q, rptr_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_rd, do_wr;

    sd_rx_packer #(.DW(DW)) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_width (bus_width),
        .d         (d),
        .wr        (wr),
        .flush     (flush),
        .push      (push),
        .push_data (push_data)
    );

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level = wptr_q - rptr_q;
    assign afull = (level >= LW'(AF_LVL));
    assign q     = mem_q[rptr_q[AW-1:0]];
    assign ovf   = ovf_q;

    always_comb begin
        do_rd  = rd && !empty;
        // A pop in the same cycle frees the slot a full FIFO needs.
        do_wr  = push && (!full || do_rd);
        wptr_d = wptr_q + LW'(do_wr);
        rptr_d = rptr_q + LW'(do_rd);
        ovf_d  = ovf_q;
        if (push && full && !rd) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule
